// File: rtl/cond_sum_adder16.sv
// 16-bit conditional-sum adder: {Cout,Sum} = x + y + Cin, with one registered output stage.
// Each level merges block pairs, with both carry-in hypotheses carried forward until Cin resolves them.
module cond_sum_adder16 (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        Cin,
    output logic [15:0] Sum,
    output logic        Cout
);

    // s0/c0 assume a block carry-in of 0, s1/c1 a carry-in of 1; carry bit b belongs to block b
    typedef struct packed {
        logic [15:0] s0;
        logic [15:0] s1;
        logic [15:0] c0;
        logic [15:0] c1;
    } lvl_t;

    function automatic lvl_t merge(input lvl_t lo_lvl, input int h);
        lvl_t       m;
        logic [3:0] i_lo;
        logic [3:0] i_hi;
        logic [3:0] i_cl;
        logic [3:0] i_ch;
        logic [3:0] i_b;
        m = '0;
        for (int b = 0; b < 8; b++) begin
            if (b < 8 / h) begin
                i_cl = 4'(2 * b);
                i_ch = 4'(2 * b + 1);
                i_b  = 4'(b);
                for (int k = 0; k < 8; k++) begin
                    if (k < h) begin
                        i_lo = 4'(b * 2 * h + k);
                        i_hi = 4'(b * 2 * h + h + k);
                        m.s0[i_lo] = lo_lvl.s0[i_lo];
                        m.s1[i_lo] = lo_lvl.s1[i_lo];
                        m.s0[i_hi] = lo_lvl.c0[i_cl] ? lo_lvl.s1[i_hi] : lo_lvl.s0[i_hi];
                        m.s1[i_hi] = lo_lvl.c1[i_cl] ? lo_lvl.s1[i_hi] : lo_lvl.s0[i_hi];
                    end
                end
                m.c0[i_b] = lo_lvl.c0[i_cl] ? lo_lvl.c1[i_ch] : lo_lvl.c0[i_ch];
                m.c1[i_b] = lo_lvl.c1[i_cl] ? lo_lvl.c1[i_ch] : lo_lvl.c0[i_ch];
            end
        end
        return m;
    endfunction

    // After level 4 a single 16-bit block remains; its carries sit in bit 0
    function automatic logic [16:0] final_select(input lvl_t l, input logic cin);
        logic [16:0] r;
        r = cin ? {l.c1[0], l.s1} : {l.c0[0], l.s0};
        return r;
    endfunction

    lvl_t        w_l0;
    lvl_t        w_l1;
    lvl_t        w_l2;
    lvl_t        w_l3;
    lvl_t        w_l4;
    logic [16:0] w_result;
    logic [15:0] r_sum;
    logic        r_cout;

    always_comb begin
        w_l0.s0 = x ^ y;
        w_l0.c0 = x & y;
        w_l0.s1 = ~(x ^ y);
        w_l0.c1 = x | y;
    end

    assign w_l1     = merge(w_l0, 1);
    assign w_l2     = merge(w_l1, 2);
    assign w_l3     = merge(w_l2, 4);
    assign w_l4     = merge(w_l3, 8);
    assign w_result = final_select(w_l4, Cin);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum  <= 16'h0000;
            r_cout <= 1'b0;
        end else begin
            r_sum  <= w_result[15:0];
            r_cout <= w_result[16];
        end
    end

    assign Sum  = r_sum;
    assign Cout = r_cout;

endmodule

// File: tb/tb_cond_sum_adder16.sv
// Bench for cond_sum_adder16: plain-arithmetic reference checked every cycle,
// directed literal cases, random and swept streams, and asynchronous reset pulses.
module tb_cond_sum_adder16;

    logic        clk;
    logic        rst;
    logic [15:0] x;
    logic [15:0] y;
    logic        Cin;
    logic [15:0] Sum;
    logic        Cout;

    int n_tests;
    int n_fail;

    cond_sum_adder16 dut (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .y   (y),
        .Cin (Cin),
        .Sum (Sum),
        .Cout(Cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {Cout,Sum}=%05h, expected %05h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: 17-bit sum of the operands seen at this edge, or zero under reset
    always @(posedge clk) begin
        logic [16:0] e;
        if (rst) e = 17'h0;
        else     e = {1'b0, x} + {1'b0, y} + {16'h0, Cin};
        #1;
        check("stream", {Cout, Sum}, e);
    end

    task automatic directed(input string name, input logic [15:0] a, input logic [15:0] b,
                            input logic c, input logic [16:0] exp);
        @(negedge clk);
        x   = a;
        y   = b;
        Cin = c;
        @(posedge clk);
        #2;
        check(name, {Cout, Sum}, exp);
    endtask

    task automatic reset_pulse(input string name);
        #1 rst = 1'b1;
        #1 check(name, {Cout, Sum}, 17'h0);
        #1 rst = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        x   = 16'h1234;
        y   = 16'h4321;
        Cin = 1'b0;
        #2 check("reset_immediate", {Cout, Sum}, 17'h0);
        repeat (3) @(posedge clk);
        #2 check("reset_hold", {Cout, Sum}, 17'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #2 check("first_after_reset", {Cout, Sum}, 17'h0_5555);

        directed("ffff_plus_1",   16'hFFFF, 16'h0001, 1'b0, 17'h1_0000);
        directed("00ff_plus_1",   16'h00FF, 16'h0001, 1'b0, 17'h0_0100);
        directed("ffff_cin",      16'hFFFF, 16'h0000, 1'b1, 17'h1_0000);
        directed("zero",          16'h0000, 16'h0000, 1'b0, 17'h0_0000);
        directed("zero_cin",      16'h0000, 16'h0000, 1'b1, 17'h0_0001);
        directed("max_nocin",     16'hFFFF, 16'hFFFF, 1'b0, 17'h1_FFFE);
        directed("max_cin",       16'hFFFF, 16'hFFFF, 1'b1, 17'h1_FFFF);
        directed("blk_8000",      16'h8000, 16'h8000, 1'b0, 17'h1_0000);
        directed("blk_0080",      16'h0080, 16'h0080, 1'b0, 17'h0_0100);
        directed("blk_0f0f",      16'h0F0F, 16'h00F1, 1'b0, 17'h0_1000);
        directed("blk_7fff",      16'h7FFF, 16'h0001, 1'b0, 17'h0_8000);
        directed("mixed_a5",      16'hA5A5, 16'h5A5A, 1'b1, 17'h1_0000);

        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            x   = 16'($urandom);
            y   = 16'($urandom);
            Cin = 1'($urandom_range(0, 1));
            if (i == 3000 || i == 7777) reset_pulse("midstream_reset");
        end

        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                @(negedge clk);
                x   = 16'(a);
                y   = 16'(b);
                Cin = 1'((a ^ b ^ (b >> 1)) & 1);
            end
        end

        @(negedge clk);
        x   = 16'hFFFF;
        y   = 16'h0000;
        Cin = 1'b1;
        reset_pulse("late_reset");
        @(posedge clk);
        #2 check("post_reset_first", {Cout, Sum}, 17'h1_0000);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
